// File: rtl/sparc_ifu_icpar_chk.sv
// Icache fetch parity checker: two-stage recompute/compare pipeline, first-error
// capture, error-handler request/acknowledge handshake and one-shot line invalidate.
module sparc_ifu_icpar_chk #(
    parameter int WIDTH = 34,
    parameter int IDX_W = 7,
    parameter int CNT_W = 4
) (
    input  logic             rclk,
    input  logic             reset,
    input  logic             rd_vld,
    input  logic [WIDTH-1:0] rd_data,
    input  logic             rd_par,
    input  logic [1:0]       rd_way,
    input  logic [IDX_W-1:0] rd_index,
    input  logic             chk_en,
    input  logic             err_ack,
    input  logic             clr_cnt,
    output logic             perr_vld,
    output logic             perr,
    output logic             err_req,
    output logic [1:0]       err_way,
    output logic [IDX_W-1:0] err_index,
    output logic             inv_vld,
    output logic             err_multi,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        INV
    } state_t;

    state_t state, state_nxt;

    logic             s1_vld;
    logic [WIDTH-1:0] s1_data;
    logic             s1_par;
    logic [1:0]       s1_way;
    logic [IDX_W-1:0] s1_idx;
    logic             s1_chk;

    logic [1:0]       s2_way;
    logic [IDX_W-1:0] s2_idx;

    logic det;
    logic capture;
    logic multi_set;

    // Stage 1: payload only loads on a valid read; the valid bit is flopped every cycle.
    always_ff @(posedge rclk) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
            s1_par  <= 1'b0;
            s1_way  <= '0;
            s1_idx  <= '0;
            s1_chk  <= 1'b0;
        end else begin
            s1_vld <= rd_vld;
            if (rd_vld) begin
                s1_data <= rd_data;
                s1_par  <= rd_par;
                s1_way  <= rd_way;
                s1_idx  <= rd_index;
                s1_chk  <= chk_en;
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            perr_vld <= 1'b0;
            perr     <= 1'b0;
            s2_way   <= '0;
            s2_idx   <= '0;
        end else begin
            perr_vld <= s1_vld;
            perr     <= s1_vld & s1_chk & (^s1_data ^ s1_par);
            s2_way   <= s1_way;
            s2_idx   <= s1_idx;
        end
    end

    assign det = perr_vld & perr;

    always_ff @(posedge rclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        err_req   = 1'b0;
        inv_vld   = 1'b0;
        unique case (state)
            IDLE: begin
                if (det) begin
                    state_nxt = REQ;
                    capture   = 1'b1;
                end
            end
            REQ: begin
                err_req = 1'b1;
                if (err_ack) begin
                    state_nxt = INV;
                end
            end
            INV: begin
                inv_vld   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Any detection outside IDLE lands while an earlier error is still owned by the handler.
    assign multi_set = det & (state != IDLE);

    always_ff @(posedge rclk) begin
        if (reset) begin
            err_way   <= '0;
            err_index <= '0;
        end else if (capture) begin
            err_way   <= s2_way;
            err_index <= s2_idx;
        end
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            err_cnt   <= '0;
            err_multi <= 1'b0;
        end else if (clr_cnt) begin
            err_cnt   <= '0;
            err_multi <= 1'b0;
        end else begin
            if (det && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            if (multi_set) begin
                err_multi <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sparc_ifu_icpar_chk.sv
// Randomized self-checking bench for sparc_ifu_icpar_chk against a cycle-level
// behavioural model built from read records flowing through a two-deep delay.
module tb_sparc_ifu_icpar_chk;

    logic        rclk;
    logic        reset;
    logic        rd_vld;
    logic [33:0] rd_data;
    logic        rd_par;
    logic [1:0]  rd_way;
    logic [6:0]  rd_index;
    logic        chk_en;
    logic        err_ack;
    logic        clr_cnt;
    logic        perr_vld;
    logic        perr;
    logic        err_req;
    logic [1:0]  err_way;
    logic [6:0]  err_index;
    logic        inv_vld;
    logic        err_multi;
    logic [3:0]  err_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    sparc_ifu_icpar_chk #(
        .WIDTH(34),
        .IDX_W(7),
        .CNT_W(4)
    ) dut (
        .rclk     (rclk),
        .reset    (reset),
        .rd_vld   (rd_vld),
        .rd_data  (rd_data),
        .rd_par   (rd_par),
        .rd_way   (rd_way),
        .rd_index (rd_index),
        .chk_en   (chk_en),
        .err_ack  (err_ack),
        .clr_cnt  (clr_cnt),
        .perr_vld (perr_vld),
        .perr     (perr),
        .err_req  (err_req),
        .err_way  (err_way),
        .err_index(err_index),
        .inv_vld  (inv_vld),
        .err_multi(err_multi),
        .err_cnt  (err_cnt)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Behavioural model: a read is a record {valid, bad, way, idx}; it surfaces two edges later.
    typedef struct {
        bit       vld;
        bit       bad;
        bit [1:0] way;
        bit [6:0] idx;
    } rec_t;

    rec_t     m_s1, m_out;
    int       m_phase;   // 0 = nothing pending, 1 = waiting for handler, 2 = invalidating
    bit [1:0] m_way;
    bit [6:0] m_idx;
    bit       m_multi;
    int       m_cnt;

    function automatic logic [17:0] exp_vec();
        return {logic'(m_out.vld), logic'(m_out.vld && m_out.bad), logic'(m_phase == 1),
                m_way, m_idx, logic'(m_phase == 2), logic'(m_multi), 4'(m_cnt)};
    endfunction

    logic [17:0] dut_vec;
    assign dut_vec = {perr_vld, perr, err_req, err_way, err_index, inv_vld, err_multi, err_cnt};

    task automatic step();
        bit   det;
        rec_t nrec;
        @(posedge rclk);
        if (reset) begin
            m_s1 = '{0, 0, 0, 0};
            m_out = '{0, 0, 0, 0};
            m_phase = 0; m_way = 0; m_idx = 0; m_multi = 0; m_cnt = 0;
        end else begin
            det = m_out.vld && m_out.bad;
            if (clr_cnt) begin
                m_cnt = 0;
                m_multi = 0;
            end else if (det) begin
                if (m_cnt < 15) m_cnt = m_cnt + 1;
                if (m_phase != 0) m_multi = 1;
            end
            case (m_phase)
                0: if (det) begin m_phase = 1; m_way = m_out.way; m_idx = m_out.idx; end
                1: if (err_ack) m_phase = 2;
                default: m_phase = 0;
            endcase
            nrec.vld = rd_vld;
            nrec.bad = chk_en && ((($countones(rd_data) + int'(rd_par)) % 2) == 1);
            nrec.way = rd_way;
            nrec.idx = rd_index;
            m_out = m_s1;
            if (rd_vld) m_s1 = nrec;
            else m_s1.vld = 0;
        end
        #1;
        rd_vld = 1'b0;
        err_ack = 1'b0;
        clr_cnt = 1'b0;
    endtask

    task automatic put_read(input bit bad, input logic [1:0] w, input logic [6:0] i);
        logic [63:0] r;
        r = {$urandom, $urandom};
        rd_vld = 1'b1;
        rd_data = r[33:0];
        rd_par = (^r[33:0]) ^ bad;
        rd_way = w;
        rd_index = i;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_vec++;
            if (dut_vec !== 18'h0) begin
                n_fail++;
                $display("FAIL reset_state cyc %0d: got %h want %h", c, dut_vec, 18'h0);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_good_read();
        chk_en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 0) begin
                rd_vld = 1'b1; rd_data = 34'h0; rd_par = 1'b0; rd_way = 2'd0; rd_index = 7'h0;
            end
            step();
            n_vec++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL good_read cyc %0d: got %h want %h", c, dut_vec, exp_vec());
            end
            if (c == 1) begin
                n_vec++;
                if ({perr_vld, perr, err_cnt} !== {1'b1, 1'b0, 4'd0}) begin
                    n_fail++;
                    $display("FAIL good_read_result: got %b want %b", {perr_vld, perr, err_cnt}, 6'b100000);
                end
            end
        end
    endtask

    task automatic test_single_error();
        for (int c = 0; c < 8; c++) begin
            if (c == 0) begin
                rd_vld = 1'b1; rd_data = 34'h1; rd_par = 1'b0; rd_way = 2'd2; rd_index = 7'h15;
            end
            if (c == 5) err_ack = 1'b1;
            step();
            n_vec++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_error cyc %0d: got %h want %h", c, dut_vec, exp_vec());
            end
            if (c == 1 && {perr_vld, perr, err_req} !== 3'b110) begin
                n_fail++;
                $display("FAIL single_error_perr: got %b want 110", {perr_vld, perr, err_req});
            end
            if (c == 2 && {err_req, err_way, err_index} !== {1'b1, 2'd2, 7'h15}) begin
                n_fail++;
                $display("FAIL single_error_capture: got %h want %h", {err_req, err_way, err_index},
                         {1'b1, 2'd2, 7'h15});
            end
            if (c == 5 && {inv_vld, err_req} !== 2'b10) begin
                n_fail++;
                $display("FAIL single_error_inv: got %b want 10", {inv_vld, err_req});
            end
            if (c == 6 && {inv_vld, err_req} !== 2'b00) begin
                n_fail++;
                $display("FAIL single_error_inv_once: got %b want 00", {inv_vld, err_req});
            end
        end
        n_vec += 4;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 9; c++) begin
            if (c == 0) clr_cnt = 1'b1;
            if (c == 1) put_read(1'b1, 2'd1, 7'h22);
            if (c == 2) put_read(1'b1, 2'd3, 7'h33);
            if (c == 6) err_ack = 1'b1;
            step();
            n_vec++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL back_to_back cyc %0d: got %h want %h", c, dut_vec, exp_vec());
            end
            if (c == 5) begin
                n_vec++;
                if ({err_way, err_index, err_multi, err_cnt} !== {2'd1, 7'h22, 1'b1, 4'd2}) begin
                    n_fail++;
                    $display("FAIL back_to_back_first_wins: got %h want %h",
                             {err_way, err_index, err_multi, err_cnt}, {2'd1, 7'h22, 1'b1, 4'd2});
                end
            end
        end
    endtask

    task automatic test_chk_disabled();
        for (int c = 0; c < 5; c++) begin
            if (c == 0) clr_cnt = 1'b1;
            if (c == 1) begin chk_en = 1'b0; put_read(1'b1, 2'd3, 7'h7f); end
            if (c == 2) chk_en = 1'b1;
            step();
            n_vec++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL chk_disabled cyc %0d: got %h want %h", c, dut_vec, exp_vec());
            end
            if (c == 2) begin
                n_vec++;
                if ({perr_vld, perr, err_req, err_cnt} !== 7'b1000000) begin
                    n_fail++;
                    $display("FAIL chk_disabled_result: got %b want 1000000", {perr_vld, perr, err_req, err_cnt});
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int c = 0; c < 102; c++) begin
            if (c < 100 && c % 5 == 0) put_read(1'b1, 2'($urandom), 7'($urandom));
            if (c < 100 && c % 5 == 3) err_ack = 1'b1;
            if (c == 101) clr_cnt = 1'b1;
            step();
            n_vec++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL saturation cyc %0d: got %h want %h", c, dut_vec, exp_vec());
            end
            if (c == 100 && err_cnt !== 4'd15) begin
                n_fail++;
                $display("FAIL saturation_cnt: got %0d want 15", err_cnt);
            end
            if (c == 101 && {err_cnt, err_multi} !== 5'b0) begin
                n_fail++;
                $display("FAIL saturation_clear: got %b want 00000", {err_cnt, err_multi});
            end
        end
        n_vec += 2;
    endtask

    task automatic test_reset_midop();
        for (int c = 0; c < 8; c++) begin
            if (c == 0) put_read(1'b1, 2'd2, 7'h0a);
            if (c == 3) put_read(1'b1, 2'd1, 7'h0b);
            reset = (c == 4);
            step();
            n_vec++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_midop cyc %0d: got %h want %h", c, dut_vec, exp_vec());
            end
            if (c == 3 && err_req !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_midop_in_req: got %b want 1", err_req);
            end
            if ((c == 4 || c == 5) && dut_vec !== 18'h0) begin
                n_fail++;
                $display("FAIL reset_midop_flush cyc %0d: got %h want %h", c, dut_vec, 18'h0);
            end
        end
        n_vec += 3;
        reset = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(1, 0) == 1) put_read($urandom_range(9, 0) < 3, 2'($urandom), 7'($urandom));
            chk_en = ($urandom_range(9, 0) < 8);
            err_ack = ($urandom_range(4, 0) == 0);
            clr_cnt = ($urandom_range(39, 0) == 0);
            reset = ($urandom_range(99, 0) == 0);
            step();
            n_vec++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h want %h", c, dut_vec, exp_vec());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rd_vld = 1'b0; rd_data = '0; rd_par = 1'b0; rd_way = '0; rd_index = '0;
        chk_en = 1'b1; err_ack = 1'b0; clr_cnt = 1'b0;
        m_s1 = '{0, 0, 0, 0};
        m_out = '{0, 0, 0, 0};
        m_phase = 0; m_way = 0; m_idx = 0; m_multi = 0; m_cnt = 0;
        #2;
        test_reset();
        test_good_read();
        test_single_error();
        test_back_to_back();
        test_chk_disabled();
        test_saturation();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
